// File: rtl/exp_table_pingpong.sv
// Ping-pong table store: the generator fills the write bank while the cores read
// the other one; a swap exchanges the banks once the write bank is complete.
module exp_table_pingpong #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int DATA_W = 18
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [ADDR_W-1:0] iWrAddr,
  input  logic [DATA_W-1:0] iWrData,
  input  logic              iWrValid,
  input  logic              iWrDone,
  input  logic              iSwap,
  input  logic              iRdEn,
  input  logic [ADDR_W-1:0] iRdAddr,
  output logic [DATA_W-1:0] oRdData,
  output logic              oRdValid,
  output logic              oReady,
  output logic              oSel,
  output logic              oErr
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem0_q [DEPTH];
  logic [DATA_W-1:0] mem1_q [DEPTH];

  logic              sel_q, sel_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc;
  logic              rd_vld_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              wr_ok;
  logic              wr_in_range;
  logic              swap_ok;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  always_comb begin
    wr_ok       = iWrValid && !ready_q;
    wr_in_range = ({1'b0, iWrAddr} < DEPTH_C);
    swap_ok     = iSwap && ready_q;
    wr_idx      = iWrAddr[IDX_W-1:0];
    rd_idx      = iRdAddr[IDX_W-1:0];
    cnt_inc     = cnt_q + 1'b1;

    sel_d   = sel_q;
    ready_d = ready_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // Beats are counted even when the address is out of range.
    if (wr_ok) cnt_d = cnt_inc;

    if ((iWrValid && ready_q) || (wr_ok && !wr_in_range) || (iSwap && !ready_q))
      err_d = 1'b1;

    // swap_ok and wr_ok are mutually exclusive, so a write never meets a swap.
    if (swap_ok) begin
      sel_d   = ~sel_q;
      ready_d = 1'b0;
      cnt_d   = '0;
    end else if (iWrDone || (wr_ok && (cnt_inc >= DEPTH_C))) begin
      ready_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sel_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sel_q   <= sel_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write bank is the one not being read.
  always_ff @(posedge CLK) begin
    if (wr_ok && wr_in_range && sel_q) mem0_q[wr_idx] <= iWrData;
  end

  always_ff @(posedge CLK) begin
    if (wr_ok && wr_in_range && !sel_q) mem1_q[wr_idx] <= iWrData;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= iRdEn;
      if (iRdEn) rd_data_q <= sel_q ? mem1_q[rd_idx] : mem0_q[rd_idx];
    end
  end

  assign oRdData  = rd_data_q;
  assign oRdValid = rd_vld_q;
  assign oReady   = ready_q;
  assign oSel     = sel_q;
  assign oErr     = err_q;

endmodule

// File: tb/tb_exp_table_pingpong.sv
// Bench for exp_table_pingpong: randomized and directed traffic against a
// bank/array reference model, with read responses checked through a scoreboard.
module tb_exp_table_pingpong;

  localparam int AW    = 10;
  localparam int DEPTH = 512;
  localparam int DW    = 18;

  logic          CLK = 1'b0;
  logic          nRST;
  logic [AW-1:0] iWrAddr, iRdAddr;
  logic [DW-1:0] iWrData;
  logic          iWrValid, iWrDone, iSwap, iRdEn;
  logic [DW-1:0] oRdData;
  logic          oRdValid, oReady, oSel, oErr;

  exp_table_pingpong #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iWrAddr(iWrAddr), .iWrData(iWrData), .iWrValid(iWrValid), .iWrDone(iWrDone),
    .iSwap(iSwap), .iRdEn(iRdEn), .iRdAddr(iRdAddr),
    .oRdData(oRdData), .oRdValid(oRdValid), .oReady(oReady), .oSel(oSel), .oErr(oErr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int            cyc;
    bit            known;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model: two banks of entries, plus which entries hold defined data.
  logic [DW-1:0] mb [2][DEPTH];
  bit            mk [2][DEPTH];
  bit            m_sel, m_ready, m_err;
  int            m_cnt;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sel = 1'b0; m_ready = 1'b0; m_err = 1'b0; m_cnt = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++) mk[b][a] = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model, then check status after the edge.
  task automatic step(input bit wv, input int wa, input int wd, input bit dn,
                      input bit sw, input bit rd, input int ra);
    exp_t e;
    bit   filled;
    iWrValid = wv; iWrAddr = AW'(wa); iWrData = DW'(wd);
    iWrDone = dn; iSwap = sw; iRdEn = rd; iRdAddr = AW'(ra);
    filled = 1'b0;
    if (rd) begin
      e.cyc   = cyc;
      e.known = (ra < DEPTH) && mk[m_sel][ra];
      e.data  = e.known ? mb[m_sel][ra] : '0;
      q.push_back(e);
    end
    if (wv) begin
      if (m_ready) m_err = 1'b1;
      else begin
        m_cnt++;
        if (wa < DEPTH) begin
          mb[!m_sel][wa] = DW'(wd);
          mk[!m_sel][wa] = 1'b1;
        end else m_err = 1'b1;
        if (m_cnt >= DEPTH) filled = 1'b1;
      end
    end
    if (sw && m_ready) begin
      m_sel = !m_sel; m_ready = 1'b0; m_cnt = 0;
    end else begin
      if (sw) m_err = 1'b1;
      if (dn || filled) m_ready = 1'b1;
    end
    @(posedge CLK); #1;
    chk("sel", oSel, m_sel);
    chk("ready", oReady, m_ready);
    chk("err", oErr, m_err);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wr_rand_rd(input int a, input int d);
    step(1, a, d, 0, 0, $urandom_range(0, 1), $urandom_range(0, 599));
  endtask

  task automatic reset_pulse();
    nRST = 1'b0;
    iWrValid = 0; iWrAddr = '0; iWrData = '0; iWrDone = 0;
    iSwap = 0; iRdEn = 0; iRdAddr = '0;
    q.delete();
    model_reset();
    #1;
    chk("rst_sel", oSel, 0);
    chk("rst_ready", oReady, 0);
    chk("rst_rdvalid", oRdValid, 0);
    chk("rst_rddata", oRdData, 0);
    chk("rst_err", oErr, 0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  // Monitor: a read issued in cycle N must show up valid at cycle N+1, nothing else.
  always @(negedge CLK) begin
    bit   ev;
    exp_t e;
    ev = (q.size() > 0) && (q[0].cyc == cyc - 1);
    chk("rd_valid", oRdValid, ev);
    if (ev) begin
      e = q.pop_front();
      if (oRdValid && e.known) chk("rd_data", oRdData, e.data);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    iWrValid = 0; iWrAddr = '0; iWrData = '0; iWrDone = 0;
    iSwap = 0; iRdEn = 0; iRdAddr = '0;
    model_reset();
    @(posedge CLK); #1;

    // Full fill of bank 1, then swap and read it back.
    reset_pulse();
    for (int i = 0; i < DEPTH; i++) wr_rand_rd(i, i * 3);
    chk("t1_ready", oReady, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 5);
    idle();
    chk("t1_rd5", oRdData, 15);

    // Fill bank 0 while bank 1 is being read.
    for (int i = 0; i < 40; i++) step(1, i, (i == 5) ? 7 : $urandom_range(0, 262143), 0, 0, 1, 5);
    step(0, 0, 0, 1, 0, 1, 5);
    step(0, 0, 0, 0, 1, 1, 5);
    step(0, 0, 0, 0, 0, 1, 5);
    idle();
    chk("t4_rd5", oRdData, 7);

    // Swap, read and write all in the same cycle.
    for (int i = 0; i < 3; i++) step(1, 100 + i, $urandom_range(0, 262143), 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(1, 5, 999, 0, 1, 1, 5);
    idle();
    chk("t5_rd_preswap", oRdData, 7);
    chk("t5_sel", oSel, 1);
    step(0, 0, 0, 0, 0, 1, 5);
    idle();
    chk("t5_write_dropped", oRdData, 15);

    // Premature swap, then the count resumes to a full bank.
    reset_pulse();
    for (int i = 0; i < 10; i++) wr_rand_rd(i, $urandom_range(0, 262143));
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t3_err", oErr, 1);
    for (int i = 10; i < DEPTH - 1; i++) wr_rand_rd(i, $urandom_range(0, 262143));
    chk("t3_not_ready", oReady, 0);
    wr_rand_rd(DEPTH - 1, 12345);
    step(0, 0, 0, 0, 1, 0, 0);

    // Early done, and a final beat together with done.
    for (int i = 0; i < 100; i++) wr_rand_rd(i, $urandom_range(0, 262143));
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 99; i++) wr_rand_rd(i, $urandom_range(0, 262143));
    step(1, 99, 4242, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 99);
    idle();
    chk("t2_last_beat", oRdData, 4242);

    // Random soak, including out-of-range addresses.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, $urandom_range(0, 599), $urandom_range(0, 262143),
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
           $urandom_range(0, 1), $urandom_range(0, 599));

    // Reset mid-fill with a read outstanding, then a full refill.
    reset_pulse();
    for (int i = 0; i < 200; i++) wr_rand_rd(i, $urandom_range(0, 262143));
    step(0, 0, 0, 0, 0, 1, 5);
    reset_pulse();
    for (int i = 0; i < DEPTH - 1; i++) wr_rand_rd(i, i + 1);
    chk("t6_not_ready", oReady, 0);
    wr_rand_rd(DEPTH - 1, DEPTH);
    chk("t6_ready", oReady, 1);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 200);
    idle();
    chk("t6_rd200", oRdData, 201);

    idle(); idle();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exp_table_pingpong.md
Name: exp_table_pingpong

Overview:
- Receiving end of the ExpMu/ExpSigma table write stream (addr/data/valid plus done pulse).
- Holds two table banks. The generator fills the write bank while the MC cores read the other bank.
- A swap pulse, driven by the top-level startCores, exchanges the two banks.
- Replaces the ad-hoc Switch register and per-core table storage with one instance per table.

Parameters:
ADDR_W, 9, table address width (9 for ExpMu, pathWidth=10 for ExpSigma)
DEPTH, 512, number of entries per bank; must be at most 2^ADDR_W
DATA_W, 18, table entry width

Ports:
CLK  input  1  clock; all logic on rising edge
nRST  input  1  asynchronous active-low reset
iWrAddr  input  ADDR_W  write address from the generator
iWrData  input  DATA_W  write data from the generator
iWrValid  input  1  write strobe, one entry per cycle
iWrDone  input  1  single-cycle pulse: generator finished the table
iSwap  input  1  single-cycle request to exchange the banks
iRdEn  input  1  read request from the cores
iRdAddr  input  ADDR_W  read address
oRdData  output  DATA_W  registered read data
oRdValid  output  1  read data valid
oReady  output  1  write bank complete; a swap is allowed
oSel  output  1  index of the bank currently being read
oErr  output  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, nRST low):
  - oSel=0, oReady=0, oRdValid=0, oRdData=0, oErr=0, fill counter=0.
  - RAM contents are not reset and are undefined.
- Banks: the read bank is oSel; the write bank is ~oSel.
- Write path:
  - On iWrValid with oReady=0: write iWrData at iWrAddr in the write bank and increment the fill counter (ADDR_W+1 bits).
  - The counter counts beats, not unique addresses.
  - iWrAddr >= DEPTH: write suppressed, oErr set, counter still increments.
- Ready:
  - oReady sets on the edge after either iWrDone=1 or the counter reaching DEPTH, whichever comes first.
  - A write and iWrDone in the same cycle: the write is performed and oReady sets on that edge.
- Write while oReady=1: dropped, memory unchanged, oErr set.
- Swap:
  - iSwap with oReady=1: on that edge oSel toggles, oReady clears and the counter clears.
  - iSwap with oReady=0: ignored, oSel unchanged, oErr set.
  - Same-cycle iSwap and iWrValid: the write is evaluated against the pre-swap state. If oReady=1 the write is dropped with oErr; a valid write can never land in the new read bank.
- Read path:
  - Latency 1. iRdEn at cycle N gives oRdData = read bank[iRdAddr] and oRdValid=1 at cycle N+1.
  - oRdValid=0 whenever iRdEn was 0 in the previous cycle; oRdData then holds its last value.
  - iRdAddr >= DEPTH returns undefined data with oRdValid=1 and no error.
- Simultaneous read and swap: the read issued in the swap cycle uses the pre-swap oSel. Reads from the next cycle on see the new bank.
- Read/write independence: writes never target the read bank, so read-during-write needs no forwarding.
- Reset mid-fill discards progress. After reset, bank 1 is the write bank and must be refilled.
- oErr clears only on reset.
- Storage: two DEPTH x DATA_W arrays, or one 2*DEPTH array addressed by {bank, addr}. The array must infer block RAM: synchronous read, no reset on the array.

Test Plan:
1. Full fill and swap:
   - Reset, then 512 writes to bank 1 with data = addr*3.
   - Expect oReady=1 the edge after the 512th beat.
   - iSwap: oSel=1, oReady=0.
   - iRdEn at addr 5: oRdData=15, oRdValid=1 the next cycle.
2. Early done:
   - Write 100 entries, then pulse iWrDone.
   - Expect oReady=1 next edge, counter at 100; iSwap is then accepted.
   - Write beat 100 together with iWrDone: oReady sets on that edge and the entry is stored.
3. Premature swap:
   - iSwap after 10 writes.
   - Expect oSel unchanged, oReady=0, oErr=1; the counter continues from 10.
4. Concurrent fill and read:
   - Bank 1 holds addr*3 and is being read; meanwhile write bank 0 with data=7 at addr 5.
   - Reads of addr 5 return 15 until the swap; after the swap they return 7.
5. Swap-cycle collisions:
   - Same cycle: iSwap, iRdEn at addr 5, iWrValid.
   - Read returns the pre-swap bank value; the write is dropped; oErr=1; oSel toggles.
6. Reset mid-operation:
   - Assert nRST low for 1 cycle during a fill at count 200 with an outstanding read.
   - Expect immediately: oSel=0, oReady=0, oRdValid=0, oRdData=0, oErr=0.
   - A full refill is then required before oReady rises.
